// File: rtl/master_tx_port.sv
// Serial master transmit port: handshake, then LSB-first header and burst beats; first bit rides the handshake cycle.
// Waits on slave_ready up to TIMEOUT cycles; burst beats are pulled from the core via data_req, one gap cycle each.
module master_tx_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 13,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_data,
  input  logic [BURST_WIDTH-1:0] req_burst,
  input  logic                   slave_ready,
  output logic                   master_valid,
  output logic                   tx_address,
  output logic                   tx_data,
  output logic                   tx_burst,
  output logic                   read_en,
  output logic                   write_en,
  output logic                   busy,
  output logic                   data_req,
  output logic                   done,
  output logic                   timeout_err
);

  localparam int BCW     = BURST_WIDTH - 1;
  localparam int HDR_ONE = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int HDR_MAX = (BURST_WIDTH > HDR_ONE) ? BURST_WIDTH : HDR_ONE;
  localparam int CW      = $clog2(HDR_MAX + 1);

  localparam logic [CW-1:0] HDR_LAST_SINGLE = CW'(HDR_ONE - 1);
  localparam logic [CW-1:0] HDR_LAST_BURST  = CW'(HDR_MAX - 1);
  localparam logic [CW-1:0] BEAT_LAST       = CW'(DATA_WIDTH - 1);
  localparam logic [7:0]    TIMEOUT_CNT     = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WAIT_HS, HEADER, BEAT_GAP, BEAT, FINISH} state_t;

  state_t                 state, state_n;
  logic                   wr_q, flag_q;
  logic [ADDR_WIDTH-1:0]  addr_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic [BURST_WIDTH-1:0] burst_sr;
  logic [BCW-1:0]         beat_total, beat_cnt;
  logic [CW-1:0]          bit_cnt;
  logic [7:0]             wait_cnt;
  logic                   hs, timed_out, hdr_end, beat_end, more_beats;

  assign timed_out  = (wait_cnt == TIMEOUT_CNT);
  assign hdr_end    = (bit_cnt == (flag_q ? HDR_LAST_BURST : HDR_LAST_SINGLE));
  assign beat_end   = (bit_cnt == BEAT_LAST);
  assign more_beats = (({1'b0, beat_cnt} + BURST_WIDTH'(1)) < {1'b0, beat_total});
  assign busy       = (state != IDLE);

  always_comb begin
    state_n      = state;
    hs           = 1'b0;
    master_valid = 1'b0;
    tx_address   = 1'b0;
    tx_data      = 1'b0;
    tx_burst     = 1'b0;
    read_en      = 1'b0;
    write_en     = 1'b0;
    data_req     = 1'b0;
    done         = 1'b0;
    timeout_err  = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_n = WAIT_HS;
      end
      WAIT_HS: begin
        if (timed_out) begin
          timeout_err = 1'b1;
          state_n     = IDLE;
        end else begin
          master_valid = 1'b1;
          read_en      = !wr_q;
          write_en     = wr_q;
          tx_address   = addr_sr[0];
          tx_data      = wr_q & data_sr[0];
          tx_burst     = burst_sr[0];
          if (slave_ready) begin
            hs      = 1'b1;
            state_n = HEADER;
          end
        end
      end
      HEADER: begin
        read_en    = !wr_q;
        write_en   = wr_q;
        tx_address = addr_sr[0];
        tx_data    = wr_q & data_sr[0];
        tx_burst   = burst_sr[0];
        if (hdr_end)
          state_n = (wr_q && flag_q && (beat_total != '0)) ? BEAT_GAP : FINISH;
      end
      BEAT_GAP: begin
        read_en  = !wr_q;
        write_en = wr_q;
        data_req = 1'b1;
        state_n  = BEAT;
      end
      BEAT: begin
        read_en  = !wr_q;
        write_en = wr_q;
        // first bit of a beat comes straight from the core; the rest from the shifter
        tx_data  = (bit_cnt == '0) ? req_data[0] : data_sr[0];
        if (beat_end) state_n = more_beats ? BEAT_GAP : FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      flag_q     <= 1'b0;
      addr_sr    <= '0;
      data_sr    <= '0;
      burst_sr   <= '0;
      beat_total <= '0;
      beat_cnt   <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q       <= req_write;
            flag_q     <= req_burst[0];
            addr_sr    <= req_addr;
            data_sr    <= req_data;
            burst_sr   <= req_burst[0] ? req_burst : '0;
            beat_total <= req_burst[BURST_WIDTH-1:1];
            beat_cnt   <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
          end
        end
        WAIT_HS: begin
          if (hs) begin
            addr_sr  <= addr_sr >> 1;
            data_sr  <= data_sr >> 1;
            burst_sr <= burst_sr >> 1;
            bit_cnt  <= CW'(1);
          end else if (!timed_out) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HEADER: begin
          addr_sr  <= addr_sr >> 1;
          data_sr  <= data_sr >> 1;
          burst_sr <= burst_sr >> 1;
          bit_cnt  <= hdr_end ? '0 : bit_cnt + CW'(1);
        end
        BEAT_GAP: bit_cnt <= '0;
        BEAT: begin
          data_sr <= (bit_cnt == '0) ? (req_data >> 1) : (data_sr >> 1);
          if (beat_end) begin
            bit_cnt  <= '0;
            beat_cnt <= beat_cnt + BCW'(1);
          end else begin
            bit_cnt  <= bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
